// File: rtl/token_lexer_pkg.sv
// Shared token and character definitions for the lexer and the parser.
package token_lexer_pkg;

  localparam int KIND_W  = 8;
  localparam int VALUE_W = 8;
  localparam int TOKEN_W = KIND_W + VALUE_W;

  localparam logic [KIND_W-1:0] TK_NUM  = 8'h00;
  localparam logic [KIND_W-1:0] TK_PLUS = 8'h01;
  localparam logic [KIND_W-1:0] TK_MUL  = 8'h02;
  localparam logic [KIND_W-1:0] TK_EOF  = 8'h03;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MUL   = 8'h2A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_NUL   = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NUM,
    S_EMIT,
    S_DONE,
    S_ERROR
  } lex_state_t;

  function automatic logic [TOKEN_W-1:0] make_token(input logic [KIND_W-1:0] kind,
                                                    input logic [VALUE_W-1:0] value);
    return {kind, value};
  endfunction

endpackage

// File: rtl/token_lexer_char_class.sv
// Combinational classification of one ASCII character.
module lexer_char_class
  import token_lexer_pkg::*;
(
  input  logic [7:0] ch,
  output logic       is_digit,
  output logic [3:0] digit,
  output logic       is_ws,
  output logic       is_plus,
  output logic       is_mul,
  output logic       is_nul
);

  // '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
  assign is_digit = (ch >= ASCII_0) && (ch <= ASCII_9);
  assign digit    = is_digit ? ch[3:0] : 4'd0;
  assign is_ws    = (ch == ASCII_SPACE) || (ch == ASCII_TAB) ||
                    (ch == ASCII_CR)    || (ch == ASCII_LF);
  assign is_plus  = (ch == ASCII_PLUS);
  assign is_mul   = (ch == ASCII_MUL);
  assign is_nul   = (ch == ASCII_NUL);

endmodule

// File: rtl/token_lexer.sv
// Byte-stream lexer: turns ASCII characters into {kind, value} tokens and
// offers each one to the parser until it is acknowledged.
//
// state   | meaning
// S_IDLE  | between tokens, classifying the next character
// S_NUM   | decimal literal open, accumulating digits
// S_EMIT  | token offered on o_valid/o_token, waiting for receive
// S_DONE  | EOF token acknowledged, absorbing until reset
// S_ERROR | lexical error, absorbing until reset
module token_lexer
  import token_lexer_pkg::*;
#(
  parameter int NUM_MAX = 255,
  parameter bit SKIP_WS = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [7:0]         i_char,
  output logic               o_ready,
  output logic               o_valid,
  output logic [TOKEN_W-1:0] o_token,
  input  logic               receive,
  output logic               error,
  output logic               done
);

  lex_state_t         state, state_nxt;
  logic [7:0]         acc, acc_nxt;
  logic               eof, eof_nxt;
  logic [TOKEN_W-1:0] token, token_nxt;
  logic               ready_c;
  logic [11:0]        acc_ext;

  logic       is_digit, is_ws, is_plus, is_mul, is_nul;
  logic [3:0] digit;

  lexer_char_class u_class (
    .ch       (i_char),
    .is_digit (is_digit),
    .digit    (digit),
    .is_ws    (is_ws),
    .is_plus  (is_plus),
    .is_mul   (is_mul),
    .is_nul   (is_nul)
  );

  // 12 bits hold the worst case 255*10+9 so overflow is always visible.
  assign acc_ext = ({4'd0, acc} * 12'd10) + {8'd0, digit};

  // State, accumulator, EOF flag and offered token registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      acc   <= 8'd0;
      eof   <= 1'b0;
      token <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      eof   <= eof_nxt;
      token <= token_nxt;
    end
  end

  // Next-state, accumulator update and consume decision.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    eof_nxt   = eof;
    token_nxt = token;
    ready_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          if (is_digit) begin
            ready_c   = 1'b1;
            acc_nxt   = {4'd0, digit};
            state_nxt = S_NUM;
          end else if (is_ws && SKIP_WS) begin
            ready_c = 1'b1;
          end else if (is_plus) begin
            ready_c   = 1'b1;
            token_nxt = make_token(TK_PLUS, 8'h00);
            state_nxt = S_EMIT;
          end else if (is_mul) begin
            ready_c   = 1'b1;
            token_nxt = make_token(TK_MUL, 8'h00);
            state_nxt = S_EMIT;
          end else if (is_nul) begin
            ready_c   = 1'b1;
            token_nxt = make_token(TK_EOF, 8'h00);
            eof_nxt   = 1'b1;
            state_nxt = S_EMIT;
          end else begin
            state_nxt = S_ERROR;
          end
        end
      end
      S_NUM: begin
        if (i_valid) begin
          if (is_digit) begin
            ready_c = 1'b1;
            if (acc_ext > 12'(NUM_MAX)) state_nxt = S_ERROR;
            else                        acc_nxt   = acc_ext[7:0];
          end else begin
            // Terminator stays on the input and is handled from S_IDLE later.
            token_nxt = make_token(TK_NUM, acc);
            state_nxt = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (receive) state_nxt = eof ? S_DONE : S_IDLE;
      end
      default: ;
    endcase
  end

  // Outputs decoded from the registered state; o_ready is forced low in reset.
  assign o_ready = ready_c && !rst;
  assign o_valid = (state == S_EMIT);
  assign o_token = token;
  assign error   = (state == S_ERROR);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_token_lexer.sv
// Directed bench for token_lexer with a per-cycle reference model.
module tb_token_lexer;

  localparam int MAX_V = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_char = 8'h00;
  logic        o_ready, o_valid, error, done;
  logic [15:0] o_token;
  logic        receive = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned    stim[$];
  logic [15:0]     got[$];
  int              max_hold;

  token_lexer #(.NUM_MAX(255), .SKIP_WS(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_char  (i_char),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_token (o_token),
    .receive (receive),
    .error   (error),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks "literal open", "token pending", "finished",
  // "failed" as plain flags and integers, stepped once per clock.
  bit          m_lit, m_pend, m_eof, m_fin, m_bad;
  int          m_acc;
  logic [15:0] m_tok;

  always @(negedge clk) begin : model
    bit dig, legal;
    int d, v;
    logic exp_ready;
    dig   = (i_char >= 8'h30) && (i_char <= 8'h39);
    d     = int'(i_char) - 48;
    legal = dig || i_char == 8'h2B || i_char == 8'h2A || i_char == 8'h00 ||
            i_char == 8'h20 || i_char == 8'h09 || i_char == 8'h0D || i_char == 8'h0A;
    if (rst) begin
      m_lit = 0; m_pend = 0; m_eof = 0; m_fin = 0; m_bad = 0; m_acc = 0; m_tok = 16'h0000;
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_token", o_token, 16'h0000);
      chk("rst_error", error, 0);
      chk("rst_done",  done, 0);
    end else begin
      if (m_bad || m_fin || m_pend || !i_valid) exp_ready = 0;
      else if (m_lit) exp_ready = dig;
      else            exp_ready = legal;
      chk("ready", o_ready, exp_ready);
      chk("valid", o_valid, m_pend);
      chk("token", o_token, m_tok);
      chk("error", error, m_bad);
      chk("done",  done, m_fin);
      if (m_pend) begin
        if (receive) begin
          m_pend = 0;
          if (m_eof) m_fin = 1;
        end
      end else if (!m_bad && !m_fin && i_valid) begin
        if (m_lit) begin
          if (dig) begin
            v = m_acc * 10 + d;
            if (v > MAX_V) begin m_bad = 1; m_lit = 0; end
            else m_acc = v;
          end else begin
            m_tok = {8'h00, m_acc[7:0]}; m_pend = 1; m_lit = 0;
          end
        end else if (dig) begin
          m_lit = 1; m_acc = d;
        end else if (i_char == 8'h2B) begin m_tok = 16'h0100; m_pend = 1; end
        else if (i_char == 8'h2A) begin m_tok = 16'h0200; m_pend = 1; end
        else if (i_char == 8'h00) begin m_tok = 16'h0300; m_pend = 1; m_eof = 1; end
        else if (!legal) m_bad = 1;
      end
    end
  end

  task automatic load(input string s, input bit nul);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    if (nul) stim.push_back(8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; receive = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents stim[0..lim-1] with a valid/ready handshake and acknowledges
  // each offered token dly cycles after it appears. Called at posedge+1.
  task automatic run_stream(input int dly, input int lim);
    int pos = 0, wait_cnt = 0, cyc = 0, idle = 0, hold_run = 0;
    bit take, acked;
    logic [15:0] tk, hold_tok;
    got.delete();
    max_hold = 0;
    hold_tok = 16'h0;
    while (!(done || error) && idle < 3 && cyc < 400) begin
      i_valid = (pos < lim);
      i_char  = (pos < lim) ? stim[pos] : 8'h00;
      receive = o_valid && (wait_cnt >= dly);
      @(negedge clk);
      take  = i_valid && o_ready;
      acked = receive && o_valid;
      tk    = o_token;
      if (o_valid && !o_ready && o_token == hold_tok && hold_run > 0) hold_run++;
      else if (o_valid) begin hold_run = 1; hold_tok = o_token; end
      else hold_run = 0;
      if (hold_run > max_hold) max_hold = hold_run;
      if (o_valid && !receive) wait_cnt++;
      @(posedge clk); #1;
      if (take) pos++;
      if (acked) begin got.push_back(tk); wait_cnt = 0; end
      idle = (pos >= lim && !o_valid) ? idle + 1 : 0;
      cyc++;
    end
    receive = 1'b0;
    if (cyc >= 400) chk("timeout", 1, 0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic chk_tokens(input string name, input logic [15:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(name, got[i], exp[i]);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("init_valid", o_valid, 0);
    chk("init_token", o_token, 16'h0000);
    rst = 1'b0;

    // Expression with every token kind.
    load("12+3*4", 1);
    run_stream(1, stim.size());
    chk_tokens("expr", '{16'h000C, 16'h0100, 16'h0003, 16'h0200, 16'h0004, 16'h0300});
    chk("expr_done", done, 1);
    chk("expr_error", error, 0);

    // Whitespace skipped.
    do_reset();
    load("  7 ", 1);
    run_stream(1, stim.size());
    chk_tokens("ws", '{16'h0007, 16'h0300});
    chk("ws_done", done, 1);

    // Literal at and over the limit.
    do_reset();
    load("255+256", 0);
    run_stream(1, stim.size());
    chk_tokens("ovf", '{16'h00FF, 16'h0100});
    chk("ovf_error", error, 1);
    chk("ovf_ready", o_ready, 0);

    // Illegal character after a literal.
    do_reset();
    load("9a", 0);
    run_stream(2, stim.size());
    chk_tokens("bad", '{16'h0009});
    chk("bad_error", error, 1);
    chk("bad_ready", o_ready, 0);
    chk("bad_done", done, 0);

    // Backpressure: token held while the parser stalls.
    do_reset();
    load("3+", 0);
    run_stream(6, stim.size());
    chk_tokens("bp", '{16'h0003, 16'h0100});
    chk("bp_hold", max_hold, 7);

    // Reset in the middle of a literal.
    do_reset();
    load("45", 0);
    run_stream(1, 1);
    i_valid = 1'b1; i_char = 8'h35;
    #1;
    chk("mid_ready_pre", o_ready, 1);
    rst = 1'b1;
    #1;
    chk("mid_ready", o_ready, 0);
    chk("mid_valid", o_valid, 0);
    chk("mid_token", o_token, 16'h0000);
    chk("mid_error", error, 0);
    chk("mid_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    load("8", 1);
    run_stream(1, stim.size());
    chk_tokens("restart", '{16'h0008, 16'h0300});
    chk("restart_done", done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/token_lexer.md
Name: token_lexer

Overview:
- Upstream neighbour of the LR parser: converts a byte stream of ASCII characters into 16-bit tokens {kind[15:8], value[7:0]}.
- Offers each token to the parser on O_VALID/O_TOKEN and holds it until the parser's RECEIVE pulse.
- Recognises decimal literals, '+', '*', whitespace and a NUL terminator; anything else is a sticky error.

Parameters:
- NUM_MAX, 255, largest legal literal value; must be ≤ 255. A literal exceeding it is an error.
- SKIP_WS, 1, when 1 space/tab/CR/LF are consumed silently; when 0 they are illegal characters.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- I_VALID  in  1  I_CHAR valid; upstream holds I_CHAR stable until it is consumed.
- I_CHAR  in  8  ASCII character.
- O_READY  out  1  combinational; character consumed at this edge when I_VALID && O_READY.
- O_VALID  out  1  token on O_TOKEN valid.
- O_TOKEN  out  16  [15:8] kind (NUM=0x00, PLUS=0x01, MUL=0x02, EOF=0x03), [7:0] value (literal value for NUM, else 0x00).
- RECEIVE  in  1  parser acknowledge, one-cycle pulse.
- ERROR  out  1  sticky lexical error.
- DONE  out  1  EOF token has been acknowledged.

Behaviour:
- Reset (async, any time, including mid-literal or mid-handshake): state=S_IDLE, acc=0, eof flag=0. Outputs: O_VALID=0, O_TOKEN=0x0000, ERROR=0, DONE=0. O_READY=0 while RST is high.
- States: S_IDLE, S_NUM, S_EMIT, S_DONE, S_ERROR.
- S_IDLE with I_VALID:
  - digit: O_READY=1, acc←digit, go to S_NUM.
  - whitespace with SKIP_WS=1: O_READY=1, stay in S_IDLE.
  - '+': O_READY=1, O_TOKEN←0x0100, go to S_EMIT.
  - '*': O_READY=1, O_TOKEN←0x0200, go to S_EMIT.
  - 0x00: O_READY=1, O_TOKEN←0x0300, set eof flag, go to S_EMIT.
  - any other character: O_READY=0, go to S_ERROR.
- S_NUM:
  - I_VALID and digit: O_READY=1, acc←acc*10+digit. Compute in 12 bits; if the result exceeds NUM_MAX, go to S_ERROR instead.
  - I_VALID and non-digit: O_READY=0, so the character is not consumed. O_TOKEN←{0x00, acc[7:0]}, go to S_EMIT. The held character is processed in S_IDLE after the handshake; no lookahead register is needed.
  - I_VALID=0: wait; the literal stays open.
- S_EMIT:
  - O_VALID=1, O_TOKEN stable, O_READY=0.
  - On RECEIVE=1, O_VALID clears at that edge; next state is S_DONE if the eof flag is set, else S_IDLE.
  - Earliest next O_VALID is 2 cycles after RECEIVE. This matches the parser sampling I_VALID two cycles after its RECEIVE pulse.
- RECEIVE while O_VALID=0 is ignored; RECEIVE held high for multiple cycles acknowledges only the current token.
- S_DONE: DONE=1, O_READY=0, absorbing until reset.
- S_ERROR: ERROR=1, O_VALID=0, O_READY=0, absorbing until reset.
- Latency: a single-character token gets O_VALID one cycle after it is consumed. A literal gets O_VALID one cycle after its terminating non-digit is presented.
- O_TOKEN holds its last value when O_VALID=0.

Decomposition:
- Shared package/header (also used by the parser) holds:
  - token kind constants TK_NUM, TK_PLUS, TK_MUL, TK_EOF;
  - token field widths: kind 8, value 8;
  - ASCII constants for '0', '9', '+', '*', space, tab, CR, LF, NUL.
- One combinational sub-module, lexer_char_class: I_CHAR → {is_digit, digit[3:0], is_ws, is_plus, is_mul, is_nul}.
- State machine and accumulator live in token_lexer.

Test Plan:
- Stream "12+3*4\0", RECEIVE issued 1 cycle after each O_VALID → tokens 0x000C, 0x0100, 0x0003, 0x0200, 0x0004, 0x0300 in order; DONE=1 and ERROR=0 at the end.
- Stream "  7 \0" with SKIP_WS=1 → 0x0007, 0x0300; the spaces produce no tokens.
- Stream "255+256" → 0x00FF, then 0x0100, then ERROR=1 when '6' arrives. The token 0x0100 is only present as O_VALID before the error if RECEIVE was given for it. O_READY stays 0 afterwards.
- Stream "9a" → 0x0009 emitted; after RECEIVE, 'a' is never consumed and ERROR=1.
- Backpressure: "3+" with RECEIVE delayed 6 cycles → O_TOKEN=0x0003 stable for all 6 cycles and O_READY=0 throughout; the '+' is consumed only after RECEIVE.
- Assert RST mid-literal after "4" is consumed of "45" → all outputs return to reset values immediately. Restarting with "8\0" yields 0x0008, 0x0300 with no residue of the earlier accumulator.
